// File: rtl/punc_mem_responder_pkg.sv
// Shared definitions for the PUnC memory responder: FSM states, display
// register addresses and the DSR ready-bit position.
package punc_mem_responder_pkg;

    localparam int WORD_W = 16;
    localparam int CTR_W  = 4;

    // Default LC3-style display register addresses
    localparam logic [WORD_W-1:0] DSR_ADDR_DEF = 16'hFE04;
    localparam logic [WORD_W-1:0] DDR_ADDR_DEF = 16'hFE06;

    // DSR bit that reports "display can accept a new word"
    localparam int DSR_READY_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_IO_HOLD = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // True when a 16-bit word address falls inside a 2**depth_log2 word RAM
    function automatic logic addr_in_ram(input logic [WORD_W-1:0] addr, input int depth_log2);
        return (addr >> depth_log2) == '0;
    endfunction

endpackage

// File: rtl/punc_mem_responder_array.sv
// Word RAM behind the responder: one synchronous write port shared by
// request writes and program preload, plus a combinational read port.
module punc_mem_array
    import punc_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WORD_W-1:0]     rd_data
);

    logic [WORD_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // Single write port; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/punc_mem_responder.sv
// Memory-side responder for PUnC: one request at a time, programmable wait
// states, word RAM access and an LC3-style DSR/DDR display port mapped onto
// a valid/ready output stream.
module punc_mem_responder
    import punc_mem_responder_pkg::*;
#(
    parameter int                DEPTH_LOG2  = 8,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [WORD_W-1:0] DSR_ADDR    = DSR_ADDR_DEF,
    parameter logic [WORD_W-1:0] DDR_ADDR    = DDR_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    output logic              io_tx_valid,
    output logic [WORD_W-1:0] io_tx_data,
    input  logic              io_tx_ready
);

    // Counter preset on accept; a zero WAIT_CYCLES never uses it
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(WAIT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic               we_q, we_d;
    logic [WORD_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic [WORD_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               io_tx_valid_q, io_tx_valid_d;
    logic [WORD_W-1:0]  io_tx_data_q, io_tx_data_d;

    // Access operands: live request inputs when accessing straight from IDLE
    logic               acc_we;
    logic [WORD_W-1:0]  acc_addr;
    logic [WORD_W-1:0]  acc_wdata;
    logic               do_access;
    logic [WORD_W-1:0]  dsr_word;

    logic                  ram_wr_en;
    logic [DEPTH_LOG2-1:0] ram_wr_addr;
    logic [WORD_W-1:0]     ram_wr_data;
    logic [WORD_W-1:0]     ram_rd_data;

    punc_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .wr_en   (ram_wr_en & ~rst),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (acc_addr[DEPTH_LOG2-1:0]),
        .rd_data (ram_rd_data)
    );

    // Select access operands from the live request or the latched copy
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        dsr_word                = '0;
        dsr_word[DSR_READY_BIT] = ~io_tx_valid_q;
    end

    // Next-state logic: FSM, wait counter, address decode and display register
    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        io_tx_valid_d = io_tx_valid_q & ~io_tx_ready;
        io_tx_data_d  = io_tx_data_q;
        ram_wr_en     = 1'b0;
        ram_wr_addr   = acc_addr[DEPTH_LOG2-1:0];
        ram_wr_data   = acc_wdata;
        do_access     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        ctr_d   = CTR_INIT;
                    end
                end else if (load_en && addr_in_ram(load_addr, DEPTH_LOG2)) begin
                    ram_wr_en   = 1'b1;
                    ram_wr_addr = load_addr[DEPTH_LOG2-1:0];
                    ram_wr_data = load_data;
                end
            end
            ST_WAIT: begin
                if (ctr_q == '0) begin
                    do_access = 1'b1;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            ST_IO_HOLD: begin
                // Load once the held word is gone or leaves on this edge
                if (!io_tx_valid_q || io_tx_ready) begin
                    io_tx_valid_d = 1'b1;
                    io_tx_data_d  = wdata_q;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_access) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b0;
            if (addr_in_ram(acc_addr, DEPTH_LOG2)) begin
                if (acc_we) begin
                    ram_wr_en = 1'b1;
                end else begin
                    rsp_rdata_d = ram_rd_data;
                end
            end else if (acc_addr == DSR_ADDR && !acc_we) begin
                rsp_rdata_d = dsr_word;
            end else if (acc_addr == DDR_ADDR && acc_we) begin
                if (io_tx_valid_q) begin
                    state_d = ST_IO_HOLD;
                end else begin
                    io_tx_valid_d = 1'b1;
                    io_tx_data_d  = acc_wdata;
                end
            end else begin
                rsp_err_d = 1'b1;
                if (!acc_we) begin
                    rsp_rdata_d = '0;
                end
            end
        end
    end

    // State registers; reset abandons any request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ctr_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            io_tx_valid_q <= 1'b0;
            io_tx_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            io_tx_valid_q <= io_tx_valid_d;
            io_tx_data_q  <= io_tx_data_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign io_tx_valid = io_tx_valid_q;
    assign io_tx_data  = io_tx_data_q;

endmodule

// File: tb/tb_punc_mem_responder.sv
// Self-checking bench for punc_mem_responder: transaction-level model of the
// RAM, display queue and expected responses, checked every cycle.
module tb_punc_mem_responder;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = 16'h0;
    logic [15:0] load_data = 16'h0;
    logic        io_tx_valid;
    logic [15:0] io_tx_data;
    logic        io_tx_ready = 1'b1;

    always #5 clk = ~clk;

    punc_mem_responder #(
        .DEPTH_LOG2  (8),
        .WAIT_CYCLES (W),
        .DSR_ADDR    (16'hFE04),
        .DDR_ADDR    (16'hFE06)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .io_tx_valid (io_tx_valid),
        .io_tx_data  (io_tx_data),
        .io_tx_ready (io_tx_ready)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] rdata;
        logic        err;
        logic        has_tx;
        logic [15:0] txw;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] txq[$];
    logic [15:0] ram_m [0:255];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rsp_count = 0;
    int          tx_count = 0;
    int          rsp_cyc = 0;
    int          acc_cyc = 0;
    bit          outstanding = 1'b0;
    logic [15:0] last_rdata = 16'h0;
    logic        last_err = 1'b0;
    logic [15:0] last_tx = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Per-cycle compare against the transaction model
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 16'(rsp_valid), 16'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", 16'(rsp_err), 16'(e.err));
                    if (!e.we) chk("rsp_rdata", rsp_rdata, e.rdata);
                    if (e.has_tx) txq.push_back(e.txw);
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                    rsp_cyc    = cyc;
                    rsp_count++;
                    $display("rsp #%0d we=%0d rdata=%h err=%0d cycle=%0d", rsp_count, e.we, rsp_rdata, rsp_err, cyc);
                end
            end
            chk("req_ready", 16'(req_ready), 16'(!outstanding));
            if (rsp_valid) outstanding = 1'b0;
            chk("io_tx_valid", 16'(io_tx_valid), 16'(txq.size() != 0));
            if (txq.size() != 0) begin
                chk("io_tx_data", io_tx_data, txq[0]);
                if (io_tx_valid && io_tx_ready) begin
                    last_tx = txq.pop_front();
                    tx_count++;
                    $display("io transfer #%0d data=%h cycle=%0d", tx_count, last_tx, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] addr, input logic [15:0] data);
        load_en = 1'b1; load_addr = addr; load_data = data;
        tick();
        load_en = 1'b0;
        if (addr < 16'd256) ram_m[addr[7:0]] = data;
    endtask

    // Model the request by the addressing rules, then drive it until accepted
    task automatic issue(input bit we, input logic [15:0] addr, input logic [15:0] wdata, output bit stall);
        exp_t e;
        e.we = we; e.rdata = 16'h0; e.err = 1'b0; e.has_tx = 1'b0; e.txw = wdata;
        stall = 1'b0;
        if (addr < 16'd256) begin
            if (we) ram_m[addr[7:0]] = wdata;
            else    e.rdata = ram_m[addr[7:0]];
        end else if (addr == 16'hFE04 && !we) begin
            e.rdata = (txq.size() == 0) ? 16'h8000 : 16'h0000;
        end else if (addr == 16'hFE06 && we) begin
            e.has_tx = 1'b1;
            stall    = (txq.size() != 0);
        end else begin
            e.err = 1'b1;
        end
        exp_q.push_back(e);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        outstanding = 1'b1;
        acc_cyc = cyc;
    endtask

    task automatic wait_rsp(input bit check_lat);
        int start;
        bit got;
        start = rsp_count;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (rsp_count != start) got = 1'b1;
        end
        if (!got) chk("rsp_timeout", 16'(rsp_count - start), 16'd1);
        else if (check_lat) chk("latency", 16'(rsp_cyc - acc_cyc + 1), 16'(W + 1));
    endtask

    task automatic xfer(input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        bit stall;
        issue(we, addr, wdata, stall);
        wait_rsp(!stall);
    endtask

    initial begin
        int rc;
        bit stall;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_req_ready", 16'(req_ready), 16'h1);
        chk("reset_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("reset_rsp_rdata", rsp_rdata, 16'h0);
        chk("reset_rsp_err", 16'(rsp_err), 16'h0);
        chk("reset_io_valid", 16'(io_tx_valid), 16'h0);
        chk("reset_io_data", io_tx_data, 16'h0);

        // Preload, including an out-of-range address aliasing index 5
        load(16'h0005, 16'h1234);
        load(16'h0007, 16'h0707);
        load(16'h0000, 16'h0A0A);
        load(16'h0105, 16'hDEAD);
        xfer(1'b0, 16'h0005, 16'h0);
        chk("read5_lit", last_rdata, 16'h1234);
        chk("read5_err", 16'(last_err), 16'h0);

        xfer(1'b1, 16'h0003, 16'hBEEF);
        xfer(1'b0, 16'h0003, 16'h0);
        chk("read3_lit", last_rdata, 16'hBEEF);

        // Boundary word and a spread of in-range addresses
        xfer(1'b1, 16'h00FF, 16'hC0DE);
        for (int i = 0; i < 6; i++) xfer(1'b1, 16'(32 + i * 29), 16'hA000 ^ 16'(i * 16'h0123));
        for (int i = 0; i < 6; i++) xfer(1'b0, 16'(32 + i * 29), 16'h0);
        xfer(1'b0, 16'h00FF, 16'h0);
        chk("read_ff_lit", last_rdata, 16'hC0DE);

        // Display: pending word hides DSR ready
        io_tx_ready = 1'b0;
        xfer(1'b1, 16'hFE06, 16'h0041);
        xfer(1'b0, 16'hFE04, 16'h0);
        chk("dsr_busy_lit", last_rdata, 16'h0000);
        io_tx_ready = 1'b1;
        repeat (3) tick();
        chk("tx_count_1", 16'(tx_count), 16'd1);
        xfer(1'b0, 16'hFE04, 16'h0);
        chk("dsr_ready_lit", last_rdata, 16'h8000);

        // Second DDR write stalls until the sink drains the first
        io_tx_ready = 1'b0;
        xfer(1'b1, 16'hFE06, 16'h0041);
        rc = rsp_count;
        issue(1'b1, 16'hFE06, 16'h0042, stall);
        chk("ddr2_stall_model", 16'(stall), 16'h1);
        repeat (5) tick();
        chk("ddr2_held", 16'(rsp_count - rc), 16'd0);
        io_tx_ready = 1'b1;
        wait_rsp(1'b0);
        repeat (3) tick();
        chk("tx_count_3", 16'(tx_count), 16'd3);
        chk("last_tx_lit", last_tx, 16'h0042);

        // Unmapped and wrong-direction register accesses
        xfer(1'b0, 16'h4000, 16'h0);
        chk("unmapped_rd_err", 16'(last_err), 16'h1);
        chk("unmapped_rd_data", last_rdata, 16'h0);
        xfer(1'b1, 16'h4000, 16'h5555);
        chk("unmapped_wr_err", 16'(last_err), 16'h1);
        xfer(1'b0, 16'h0000, 16'h0);
        chk("ram0_intact", last_rdata, 16'h0A0A);
        xfer(1'b0, 16'h0100, 16'h0);
        xfer(1'b0, 16'hFE06, 16'h0);
        xfer(1'b1, 16'hFE04, 16'h1111);

        // Reset in the middle of a write leaves RAM and outputs clean
        io_tx_ready = 1'b0;
        xfer(1'b1, 16'hFE06, 16'h0077);
        xfer(1'b0, 16'h0005, 16'h0);
        xfer(1'b1, 16'h4000, 16'h0);
        rc = rsp_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0007; req_wdata = 16'hFFFF;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        txq.delete();
        outstanding = 1'b0;
        tick();
        rst = 1'b0;
        io_tx_ready = 1'b1;
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0);
        chk("rst_rsp_err", 16'(rsp_err), 16'h0);
        chk("rst_io_valid", 16'(io_tx_valid), 16'h0);
        chk("rst_io_data", io_tx_data, 16'h0);
        repeat (3) tick();
        chk("rst_no_rsp", 16'(rsp_count - rc), 16'd0);
        xfer(1'b0, 16'h0007, 16'h0);
        chk("ram7_intact", last_rdata, 16'h0707);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
